// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmit feeder: byte width, default FIFO
// address width and the launch FSM state encoding.
package uart_tx_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_SEND    = 2'd2,
        S_RELEASE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo
// Synchronous byte FIFO with occupancy count, full/empty flags derived from the
// registered count, sticky overflow and a combinational head read.
//
// Ports:
//   tx_clk      in   clock
//   reset_n     in   asynchronous active-low reset
//   wr_en_i     in   write strobe (ignored while full, flags overflow instead)
//   wr_data_i   in   byte to write
//   rd_en_i     in   pop strobe (ignored while empty)
//   ovf_clr_i   in   clears sticky overflow
//   head_o      out  byte at the read pointer
//   count_o     out  entries stored
//   full_o      out  count == depth
//   empty_o     out  count == 0
//   overflow_o  out  sticky: a write was dropped while full
module tx_byte_fifo
    import uart_tx_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              tx_clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              ovf_clr_i,
    output logic [BYTE_W-1:0] head_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;

    assign full_o     = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    // Flags come from the registered count, so a byte written into an empty
    // FIFO cannot be popped until the following cycle.
    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A drop in the same cycle as a clear must stay visible.
        overflow_d = overflow_q;
        if (wr_en_i && full_o) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Buffers host bytes and feeds them to the UART bit-serial transmitter, chaining
// frames back-to-back while data remains and releasing the transmitter when the
// buffer drains or launching is disabled.
//
// Ports:
//   tx_clk               in   bit-rate clock shared with the transmitter
//   reset_n              in   asynchronous active-low reset
//   wr_en / wr_data      in   host byte write
//   tx_enable            in   allows new frames to be launched
//   overflow_clr         in   clears sticky overflow
//   tx_complete_flag     in   transmitter finished stop bit, waiting
//   tx_busy              in   transmitter frame in progress
//   tx_data              out  byte being sent, held for the whole frame
//   tx_start             out  launch request
//   tx_complete_del_flag out  returns the transmitter to idle
//   fifo_full/empty/count out buffer status (count excludes tx_data)
//   frame_done           out  one-cycle pulse per completed frame
//   overflow             out  sticky dropped-write flag
//
// Launch FSM:
//   state     | meaning
//   S_IDLE    | transmitter idle, waiting for data and enable
//   S_LAUNCH  | tx_start held until transmitter leaves its start state
//   S_SEND    | frame on the line, waiting for tx_complete_flag
//   S_RELEASE | tx_complete_del_flag held until transmitter drops busy
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              tx_clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              tx_enable,
    input  logic              overflow_clr,
    input  logic              tx_complete_flag,
    input  logic              tx_busy,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    output logic              tx_complete_del_flag,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              frame_done,
    output logic              overflow
);

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              del_q, del_d;
    logic              frame_done_q, frame_done_d;
    logic              pop;
    logic [BYTE_W-1:0] head;
    logic              launch_ok;
    logic              xmit_started;

    tx_byte_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .tx_clk     (tx_clk),
        .reset_n    (reset_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (pop),
        .ovf_clr_i  (overflow_clr),
        .head_o     (head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );

    assign launch_ok = tx_enable && !fifo_empty;
    // Busy without complete means the transmitter has accepted the start,
    // whether it came from idle or straight out of a previous stop bit.
    assign xmit_started = tx_busy && !tx_complete_flag;

    assign tx_data              = tx_data_q;
    assign tx_start             = tx_start_q;
    assign tx_complete_del_flag = del_q;
    assign frame_done           = frame_done_q;

    always_ff @(posedge tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            del_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            del_q        <= del_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (tx_complete_flag) begin
                    state_d = S_RELEASE;
                end else if (launch_ok && !tx_busy) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (xmit_started) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_complete_flag) begin
                    state_d = launch_ok ? S_LAUNCH : S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data_d    = tx_data_q;
        tx_start_d   = tx_start_q;
        del_d        = del_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                tx_start_d = 1'b0;
                del_d      = 1'b0;
                // A transmitter left waiting (e.g. reset skew) is released first.
                if (tx_complete_flag) begin
                    del_d = 1'b1;
                end else if (launch_ok && !tx_busy) begin
                    pop        = 1'b1;
                    tx_data_d  = head;
                    tx_start_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (xmit_started) begin
                    tx_start_d = 1'b0;
                end
            end
            S_SEND: begin
                if (tx_complete_flag) begin
                    frame_done_d = 1'b1;
                    if (launch_ok) begin
                        pop        = 1'b1;
                        tx_data_d  = head;
                        tx_start_d = 1'b1;
                    end else begin
                        del_d = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (!tx_busy) begin
                    del_d = 1'b0;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                del_d      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;
    import uart_tx_pkg::*;

    localparam int AW        = 4;
    localparam int FRAME_LEN = 10;
    localparam int REL_LEN   = 3;

    logic          tx_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_enable = 1'b1;
    logic          overflow_clr = 1'b0;
    logic          tx_complete_flag = 1'b0;
    logic          tx_busy = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_complete_del_flag;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          frame_done;
    logic          overflow;

    uart_tx_feeder #(.ADDR_W(AW)) dut (
        .tx_clk               (tx_clk),
        .reset_n              (reset_n),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .tx_enable            (tx_enable),
        .overflow_clr         (overflow_clr),
        .tx_complete_flag     (tx_complete_flag),
        .tx_busy              (tx_busy),
        .tx_data              (tx_data),
        .tx_start             (tx_start),
        .tx_complete_del_flag (tx_complete_del_flag),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_count           (fifo_count),
        .frame_done           (frame_done),
        .overflow             (overflow)
    );

    always #5 tx_clk = ~tx_clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // transmitter model: 0 idle, 1 sending, 2 complete/waiting, 3 releasing
    int         mst = 0;
    int         bits = 0;
    int         relcnt = 0;
    logic [7:0] cap = 8'h00;
    logic [7:0] frames[$];
    int         fd_cnt = 0;
    int         del_cnt = 0;
    int         del_at_frames = 0;
    int         both_cnt = 0;
    logic       del_prev = 1'b0;

    always @(negedge tx_clk) begin
        if (!reset_n) begin
            mst = 0;
            tx_busy = 1'b0;
            tx_complete_flag = 1'b0;
            del_prev = 1'b0;
        end else begin
            if (tx_start && tx_complete_del_flag) both_cnt++;
            if (frame_done) fd_cnt++;
            if (tx_complete_del_flag && !del_prev) begin
                del_cnt++;
                del_at_frames = frames.size();
            end
            del_prev = tx_complete_del_flag;
            case (mst)
                0: if (tx_start) begin
                    cap = tx_data; bits = FRAME_LEN; mst = 1; tx_busy = 1'b1;
                end
                1: begin
                    bits--;
                    if (bits == 0) begin
                        check_val("data_hold", 32'(tx_data), 32'(cap));
                        frames.push_back(cap);
                        mst = 2;
                        tx_complete_flag = 1'b1;
                    end
                end
                2: if (tx_start) begin
                    cap = tx_data; bits = FRAME_LEN; mst = 1; tx_complete_flag = 1'b0;
                end else if (tx_complete_del_flag) begin
                    mst = 3; relcnt = REL_LEN; tx_complete_flag = 1'b0;
                end
                default: begin
                    relcnt--;
                    if (relcnt == 0) begin
                        tx_busy = 1'b0;
                        mst = 0;
                    end
                end
            endcase
        end
    end

    task automatic write_list(input logic [7:0] vals[$]);
        @(negedge tx_clk);
        foreach (vals[i]) begin
            wr_en = 1'b1;
            wr_data = vals[i];
            @(negedge tx_clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge tx_clk); #1;
            seen = tx_start;
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(posedge tx_clk); #1;
            seen = (dut.state_q == S_IDLE) && (mst == 0) && !tx_start && !tx_complete_del_flag;
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    logic [7:0] q[$];
    int f0, fd0, d0, viol, hold_viol;
    logic seen;

    initial begin
        #1;
        check_val("rst_tx_start", 32'(tx_start), 32'd0);
        check_val("rst_empty", 32'(fifo_empty), 32'd1);
        check_val("rst_count", 32'(fifo_count), 32'd0);
        repeat (2) @(negedge tx_clk);
        reset_n = 1'b1;

        // 1: single byte, latency and release
        f0 = frames.size(); fd0 = fd_cnt; d0 = del_cnt;
        q = '{8'hA5};
        write_list(q);
        @(posedge tx_clk); #1;
        check_val("t1_start_lat", 32'(tx_start), 32'd1);
        check_val("t1_data", 32'(tx_data), 32'hA5);
        wait_idle("t1_idle");
        check_val("t1_frames", 32'(frames.size() - f0), 32'd1);
        check_val("t1_byte", 32'(frames[f0]), 32'hA5);
        check_val("t1_fdone", 32'(fd_cnt - fd0), 32'd1);
        check_val("t1_del", 32'(del_cnt - d0), 32'd1);
        check_val("t1_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        check_val("t1_empty", 32'(fifo_empty), 32'd1);

        // 2: back-to-back chaining
        f0 = frames.size(); fd0 = fd_cnt; d0 = del_cnt;
        q = '{8'h11, 8'h22, 8'h33};
        write_list(q);
        wait_idle("t2_idle");
        check_val("t2_frames", 32'(frames.size() - f0), 32'd3);
        check_val("t2_b0", 32'(frames[f0]), 32'h11);
        check_val("t2_b1", 32'(frames[f0+1]), 32'h22);
        check_val("t2_b2", 32'(frames[f0+2]), 32'h33);
        check_val("t2_fdone", 32'(fd_cnt - fd0), 32'd3);
        check_val("t2_del", 32'(del_cnt - d0), 32'd1);
        check_val("t2_del_after", 32'(del_at_frames), 32'(f0 + 3));

        // 3: fill, overflow, clear
        @(negedge tx_clk); tx_enable = 1'b0;
        f0 = frames.size();
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        write_list(q);
        check_val("t3_full", 32'(fifo_full), 32'd1);
        check_val("t3_count", 32'(fifo_count), 32'd16);
        check_val("t3_no_ovf", 32'(overflow), 32'd0);
        q = '{8'hEE};
        write_list(q);
        check_val("t3_ovf", 32'(overflow), 32'd1);
        check_val("t3_count17", 32'(fifo_count), 32'd16);
        overflow_clr = 1'b1;
        @(negedge tx_clk); overflow_clr = 1'b0;
        check_val("t3_ovf_clr", 32'(overflow), 32'd0);
        wr_en = 1'b1; wr_data = 8'hEF; overflow_clr = 1'b1;
        @(negedge tx_clk); wr_en = 1'b0; overflow_clr = 1'b0;
        check_val("t3_ovf_wins", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        @(negedge tx_clk); overflow_clr = 1'b0;
        tx_enable = 1'b1;
        wait_start("t3_start");
        wait_idle("t3_idle");
        check_val("t3_frames", 32'(frames.size() - f0), 32'd16);
        check_val("t3_first", 32'(frames[f0]), 32'h00);
        check_val("t3_last", 32'(frames[f0+15]), 32'h0F);

        // 4: disable mid-frame
        f0 = frames.size(); d0 = del_cnt;
        q = '{8'h5A, 8'hC3};
        write_list(q);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge tx_clk); #1;
            seen = tx_busy;
        end
        check_val("t4_busy", 32'(seen), 32'd1);
        @(negedge tx_clk); tx_enable = 1'b0;
        wait_idle("t4_idle");
        check_val("t4_frames", 32'(frames.size() - f0), 32'd1);
        check_val("t4_byte", 32'(frames[f0]), 32'h5A);
        check_val("t4_del", 32'(del_cnt - d0), 32'd1);
        repeat (20) @(posedge tx_clk);
        #1;
        check_val("t4_hold_start", 32'(tx_start), 32'd0);
        check_val("t4_count", 32'(fifo_count), 32'd1);
        @(negedge tx_clk); tx_enable = 1'b1;
        wait_start("t4_restart");
        check_val("t4_data2", 32'(tx_data), 32'hC3);
        wait_idle("t4_idle2");
        check_val("t4_byte2", 32'(frames[frames.size()-1]), 32'hC3);
        check_val("t4_empty", 32'(fifo_empty), 32'd1);

        // 5: reset mid-frame
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        write_list(q);
        check_val("t5_pre_count", 32'(fifo_count), 32'd4);
        reset_n = 1'b0;
        #1;
        check_val("t5_start", 32'(tx_start), 32'd0);
        check_val("t5_data", 32'(tx_data), 32'h00);
        check_val("t5_del", 32'(tx_complete_del_flag), 32'd0);
        check_val("t5_count", 32'(fifo_count), 32'd0);
        check_val("t5_empty", 32'(fifo_empty), 32'd1);
        check_val("t5_full", 32'(fifo_full), 32'd0);
        check_val("t5_fdone", 32'(frame_done), 32'd0);
        check_val("t5_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge tx_clk);
        reset_n = 1'b1;
        repeat (5) @(posedge tx_clk);
        #1;
        check_val("t5_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        check_val("t5_count_post", 32'(fifo_count), 32'd0);
        check_val("t5_no_start", 32'(tx_start), 32'd0);

        // 6: write during release
        q = '{8'h77};
        write_list(q);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge tx_clk); #1;
            seen = (dut.state_q == S_RELEASE);
        end
        check_val("t6_release", 32'(seen), 32'd1);
        q = '{8'h88};
        write_list(q);
        viol = 0; hold_viol = 0; seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge tx_clk); #1;
            seen = (dut.state_q == S_IDLE);
            if (!seen) begin
                if (tx_start) viol++;
                if (!tx_complete_del_flag) hold_viol++;
            end
        end
        check_val("t6_idle", 32'(seen), 32'd1);
        check_val("t6_no_launch", 32'(viol), 32'd0);
        check_val("t6_del_hold", 32'(hold_viol), 32'd0);
        check_val("t6_busy_low", 32'(tx_busy), 32'd0);
        check_val("t6_start_low", 32'(tx_start), 32'd0);
        check_val("t6_count", 32'(fifo_count), 32'd1);
        @(posedge tx_clk); #1;
        check_val("t6_start", 32'(tx_start), 32'd1);
        check_val("t6_data", 32'(tx_data), 32'h88);
        wait_idle("t6_done");
        check_val("t6_byte", 32'(frames[frames.size()-1]), 32'h88);

        check_val("never_both", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
